// File: rtl/seg_scan.sv
// ============================================================================
//  Module   : seg_scan
//  Brief    : Multiplexed 7-segment scanner with frame-synchronous loading.
//             Define SEG_SCAN_LZB_EN to enable leading-zero blanking.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan #(
    parameter int DIGITS    = 4,
    parameter int SCAN_DIV  = 12000,
    parameter int BLANK_CYC = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_start
);

    localparam int c_presc_w = $clog2(SCAN_DIV);
    localparam int c_idx_w   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_presc_w-1:0] c_slot_end = c_presc_w'(SCAN_DIV - 1);
    localparam logic [c_presc_w-1:0] c_blank    = c_presc_w'(BLANK_CYC);
    localparam logic [c_idx_w-1:0]   c_last_idx = c_idx_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]    c_dig_one  = DIGITS'(1);

    function automatic logic [6:0] f_seg7(input logic [3:0] nib);
        case (nib)
            4'h0:    f_seg7 = 7'h3F;
            4'h1:    f_seg7 = 7'h06;
            4'h2:    f_seg7 = 7'h5B;
            4'h3:    f_seg7 = 7'h4F;
            4'h4:    f_seg7 = 7'h66;
            4'h5:    f_seg7 = 7'h6D;
            4'h6:    f_seg7 = 7'h7D;
            4'h7:    f_seg7 = 7'h07;
            4'h8:    f_seg7 = 7'h7F;
            4'h9:    f_seg7 = 7'h6F;
            4'hA:    f_seg7 = 7'h77;
            4'hB:    f_seg7 = 7'h7C;
            4'hC:    f_seg7 = 7'h39;
            4'hD:    f_seg7 = 7'h5E;
            4'hE:    f_seg7 = 7'h79;
            default: f_seg7 = 7'h71;
        endcase
    endfunction

    logic [c_presc_w-1:0] r_presc;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_pend;
    logic [4*DIGITS-1:0]  r_pend_data;
    logic [DIGITS-1:0]    r_pend_dp;
    logic [4*DIGITS-1:0]  r_act_data;
    logic [DIGITS-1:0]    r_act_dp;

    logic                 w_slot_end;
    logic [c_idx_w-1:0]   w_idx_next;
    logic                 w_frame_wrap;
    logic [3:0]           w_nib;
    logic                 w_dp;
    logic [6:0]           w_code;

    assign w_slot_end   = (r_presc == c_slot_end);
    assign w_idx_next   = (r_idx == c_last_idx) ? '0 : r_idx + 1'b1;
    assign w_frame_wrap = w_slot_end && (w_idx_next == '0);
    assign w_nib        = r_act_data[r_idx*4 +: 4];
    assign w_dp         = r_act_dp[r_idx];

`ifdef SEG_SCAN_LZB_EN
    // Walk down from the most significant digit; digit 0 is never blanked.
    logic [DIGITS-1:0] w_lead_zero;

    always_comb begin
        logic run;
        w_lead_zero = '0;
        run         = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run            = run && (r_act_data[4*i +: 4] == 4'h0);
            w_lead_zero[i] = run;
        end
    end

    assign w_code = w_lead_zero[r_idx] ? 7'h00 : f_seg7(w_nib);
`else
    assign w_code = f_seg7(w_nib);
`endif

    // Scan timing: prescaler within a slot, digit index across slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else begin
            r_presc <= w_slot_end ? '0 : r_presc + 1'b1;
            if (w_slot_end) begin
                r_idx <= w_idx_next;
            end
        end
    end

    // Double-buffered display value; active copy only changes at frame wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
        end else begin
            if (load) begin
                r_pend_data <= data_in;
                r_pend_dp   <= dp_in;
            end
            if (w_frame_wrap && r_pend) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
            end
            if (load) begin
                r_pend <= 1'b1;
            end else if (w_frame_wrap) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Outputs lag the scan counters by one cycle, frame_start included.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg         <= 8'h00;
            dig_sel     <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= (r_presc == '0) && (r_idx == '0);
            if (!en || (r_presc < c_blank)) begin
                seg     <= 8'h00;
                dig_sel <= '1;
            end else begin
                seg     <= {w_dp, w_code};
                dig_sel <= ~(c_dig_one << r_idx);
            end
        end
    end

endmodule

`default_nettype wire
